// File: rtl/dense_layer_ctrl.sv
// Sequencer for one dense layer: walks NUM_NEURONS x NUM_INPUTS operands into an external MAC,
// then scales, saturates and optionally ReLUs each accumulator into the output buffer.
module dense_layer_ctrl #(
    parameter int  DATA_WIDTH  = 16,
    parameter int  NUM_INPUTS  = 128,
    parameter int  NUM_NEURONS = 64,
    parameter int  FRAC_BITS   = 8,
    localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
    localparam int WW = (NUM_INPUTS * NUM_NEURONS > 1) ? $clog2(NUM_INPUTS * NUM_NEURONS) : 1,
    localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
    localparam int AW = 2 * DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         relu_en,
    output logic [IW-1:0]                in_addr,
    output logic [WW-1:0]                w_addr,
    output logic                         mac_enable,
    output logic                         mac_clear,
    input  logic signed [AW-1:0]         mac_result,
    input  logic                         mac_valid,
    output logic                         out_wr_en,
    output logic [NW-1:0]                out_addr,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [IW-1:0] K_LAST = IW'(NUM_INPUTS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(NUM_NEURONS - 1);
    localparam logic signed [AW-1:0] SAT_MAX = {{(DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    state_t                 state_q, state_d;
    logic [IW-1:0]          k_q, k_d;
    logic [NW-1:0]          n_q, n_d;
    logic [WW-1:0]          w_q, w_d;
    logic                   relu_q, relu_d;
    logic signed [AW-1:0]   res_q, res_d;
    logic                   en_q;
    logic                   abort_clr_q;

    function automatic logic signed [DATA_WIDTH-1:0] scale_sat(
        input logic signed [AW-1:0] x,
        input logic                 relu
    );
        logic signed [AW-1:0] sh;
        sh = x >>> FRAC_BITS;
        if (relu && sh < 0)
            sh = '0;
        else if (sh > SAT_MAX)
            sh = SAT_MAX;
        else if (sh < SAT_MIN)
            sh = SAT_MIN;
        return sh[DATA_WIDTH-1:0];
    endfunction

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        w_d     = w_q;
        relu_d  = relu_q;
        res_d   = res_q;
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            k_d     = '0;
            n_d     = '0;
            w_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_d = CLEAR;
                        relu_d  = relu_en;
                        n_d     = '0;
                        w_d     = '0;
                    end
                end
                CLEAR: begin
                    k_d     = '0;
                    state_d = RUN;
                end
                RUN: begin
                    // w_addr keeps counting across neurons, so it always equals n*NUM_INPUTS+k
                    w_d = w_q + 1'b1;
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = DRAIN;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (mac_valid) begin
                        res_d   = mac_result;
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    if (n_q == N_LAST) begin
                        state_d = DONE;
                    end else begin
                        n_d     = n_q + 1'b1;
                        k_d     = '0;
                        state_d = RUN;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    k_d     = '0;
                    n_d     = '0;
                    w_d     = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            n_q         <= '0;
            w_q         <= '0;
            relu_q      <= 1'b0;
            res_q       <= '0;
            en_q        <= 1'b0;
            abort_clr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            n_q         <= n_d;
            w_q         <= w_d;
            relu_q      <= relu_d;
            res_q       <= res_d;
            // operands arrive one cycle after the address because the memories read synchronously
            en_q        <= (state_q == RUN) && !abort;
            abort_clr_q <= abort && (state_q != IDLE);
        end
    end

    always_comb begin
        in_addr    = k_q;
        w_addr     = w_q;
        mac_enable = en_q;
        mac_clear  = (state_q == CLEAR) || (state_q == WRITE) || abort_clr_q;
        out_wr_en  = (state_q == WRITE) && !abort;
        out_addr   = (state_q == WRITE) ? n_q : '0;
        out_data   = (state_q == WRITE) ? scale_sat(res_q, relu_q) : '0;
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
    end

endmodule

// File: tb/tb_dense_layer_ctrl.sv
// Bench for dense_layer_ctrl with behavioural memories and a two-stage MAC around it;
// expected neuron outputs come from plain dot products over the memory contents.
module tb_dense_layer_ctrl;

    localparam int DW = 16;
    localparam int NI = 4;
    localparam int NN = 3;
    localparam int FB = 0;
    localparam int IW = $clog2(NI);
    localparam int WW = $clog2(NI * NN);
    localparam int NW = $clog2(NN);
    localparam int LAT = 1 + NN * (NI + 4);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic                 relu_en = 1'b0;
    logic [IW-1:0]        in_addr;
    logic [WW-1:0]        w_addr;
    logic                 mac_enable;
    logic                 mac_clear;
    logic signed [2*DW-1:0] mac_result;
    logic                 mac_valid;
    logic                 out_wr_en;
    logic [NW-1:0]        out_addr;
    logic signed [DW-1:0] out_data;
    logic                 busy;
    logic                 done;

    dense_layer_ctrl #(
        .DATA_WIDTH (DW),
        .NUM_INPUTS (NI),
        .NUM_NEURONS(NN),
        .FRAC_BITS  (FB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .relu_en   (relu_en),
        .in_addr   (in_addr),
        .w_addr    (w_addr),
        .mac_enable(mac_enable),
        .mac_clear (mac_clear),
        .mac_result(mac_result),
        .mac_valid (mac_valid),
        .out_wr_en (out_wr_en),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // memories and MAC environment
    logic signed [DW-1:0]   in_mem [NI];
    logic signed [DW-1:0]   w_mem  [1 << WW];
    logic signed [DW-1:0]   in_rd, w_rd;
    logic signed [2*DW-1:0] prod, acc;
    logic                   en_d, vld;
    int                     mac_cnt;

    always @(posedge clk) begin
        in_rd <= in_mem[in_addr];
        w_rd  <= w_mem[w_addr];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod <= '0; en_d <= 1'b0; acc <= '0; vld <= 1'b0; mac_cnt <= 0;
        end else if (mac_clear) begin
            prod <= '0; en_d <= 1'b0; acc <= '0; vld <= 1'b0; mac_cnt <= 0;
        end else begin
            prod <= in_rd * w_rd;
            en_d <= mac_enable;
            vld  <= 1'b0;
            if (en_d) begin
                acc <= acc + prod;
                if (mac_cnt == NI - 1) begin
                    mac_cnt <= 0;
                    vld     <= 1'b1;
                end else begin
                    mac_cnt <= mac_cnt + 1;
                end
            end
        end
    end

    assign mac_result = acc;
    assign mac_valid  = vld;

    // monitor
    int cyc = 0;
    int wr_addr_q[$], wr_data_q[$], en_w_q[$], en_i_q[$];
    int done_cnt = 0, done_cyc = 0, prev_w = 0, prev_i = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_wr_en) begin
            wr_addr_q.push_back(int'(out_addr));
            wr_data_q.push_back(int'(out_data));
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (mac_enable) begin
            en_w_q.push_back(prev_w);
            en_i_q.push_back(prev_i);
        end
        prev_w = int'(w_addr);
        prev_i = int'(in_addr);
    end

    int checks = 0;
    int errors = 0;
    int exp_data[NN];

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int ref_f(input longint s, input bit relu);
        longint v;
        longint hi, lo;
        hi = (longint'(1) <<< (DW - 1)) - 1;
        lo = -(longint'(1) <<< (DW - 1));
        v = s >>> FB;
        if (relu && v < 0) v = 0;
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return int'(v);
    endfunction

    task automatic calc_exp(input bit relu);
        for (int n = 0; n < NN; n++) begin
            longint s = 0;
            for (int k = 0; k < NI; k++)
                s += longint'(in_mem[k]) * longint'(w_mem[n * NI + k]);
            exp_data[n] = ref_f(s, relu);
        end
    endtask

    task automatic fill_rand(input int r);
        for (int k = 0; k < NI; k++)
            in_mem[k] = DW'(int'($urandom_range(0, 2 * r)) - r);
        for (int j = 0; j < NI * NN; j++)
            w_mem[j] = DW'(int'($urandom_range(0, 2 * r)) - r);
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        en_w_q.delete();
        en_i_q.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    // One full pass: start, optional ignored second start, wait for done, score everything.
    task automatic run_pass(input string tag, input bit relu, input bit dbl);
        int s;
        int bad;
        int i;
        calc_exp(relu);
        clear_mon();
        relu_en = relu;
        start = 1'b1;
        tick();
        start = 1'b0;
        s = cyc;
        relu_en = ~relu;
        if (dbl) begin
            repeat (3) tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        i = 0;
        while (done_cnt == 0 && i < 300) begin
            tick();
            i++;
        end
        if (done_cnt == 0) chk({tag, "_done_timeout"}, 0, 1);
        else chk({tag, "_latency"}, done_cyc - s, LAT);
        if (dbl) repeat (60) tick();
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_wr_count"}, wr_addr_q.size(), NN);
        for (int n = 0; n < NN && n < wr_addr_q.size(); n++) begin
            chk($sformatf("%s_addr%0d", tag, n), wr_addr_q[n], n);
            chk($sformatf("%s_data%0d", tag, n), wr_data_q[n], exp_data[n]);
        end
        chk({tag, "_en_count"}, en_w_q.size(), NI * NN);
        bad = 0;
        for (int j = 0; j < en_w_q.size(); j++)
            if (en_w_q[j] != j || en_i_q[j] != j % NI) bad++;
        chk({tag, "_addr_seq_bad"}, bad, 0);
    endtask

    initial begin
        int first[NN];
        int i;

        for (int k = 0; k < NI; k++) in_mem[k] = '0;
        for (int j = 0; j < (1 << WW); j++) w_mem[j] = '0;

        // reset state
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mac_enable", mac_enable, 0);
        chk("rst_mac_clear", mac_clear, 0);
        chk("rst_out_wr_en", out_wr_en, 0);
        chk("rst_in_addr", in_addr, 0);
        chk("rst_w_addr", w_addr, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        tick();

        // ones times twos
        for (int k = 0; k < NI; k++) in_mem[k] = 16'sd1;
        for (int j = 0; j < NI * NN; j++) w_mem[j] = 16'sd2;
        run_pass("ones", 1'b0, 1'b0);
        chk("ones_value", wr_data_q.size() > 0 ? wr_data_q[0] : -1, 8);
        tick();

        // saturation both directions, then ReLU clamp
        for (int k = 0; k < NI; k++) in_mem[k] = 16'sd100;
        for (int k = 0; k < NI; k++) begin
            w_mem[k]          = 16'sd100;
            w_mem[NI + k]     = -16'sd100;
            w_mem[2 * NI + k] = DW'(int'($urandom_range(0, 20)) - 10);
        end
        run_pass("sat", 1'b0, 1'b0);
        chk("sat_pos", wr_data_q.size() > 1 ? wr_data_q[0] : 0, 32767);
        chk("sat_neg", wr_data_q.size() > 1 ? wr_data_q[1] : 0, -32768);
        tick();
        run_pass("sat_relu", 1'b1, 1'b0);
        chk("relu_neg", wr_data_q.size() > 1 ? wr_data_q[1] : -1, 0);
        tick();

        // randomized passes over small and large operand ranges
        for (int t = 0; t < 6; t++) begin
            fill_rand((t % 2 == 0) ? 60 : 3000);
            run_pass($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), 1'b0);
            tick();
        end

        // second start while running
        fill_rand(100);
        run_pass("dbl_start", 1'b0, 1'b1);
        tick();

        // abort during RUN of neuron 1
        fill_rand(100);
        calc_exp(1'b0);
        clear_mon();
        start = 1'b1;
        tick();
        start = 1'b0;
        i = 0;
        while (!out_wr_en && i < 100) begin
            tick();
            i++;
        end
        chk("abort_first_write_seen", out_wr_en, 1);
        repeat (2) tick();
        pulse_abort();
        chk("abort_busy", busy, 0);
        chk("abort_mac_clear", mac_clear, 1);
        chk("abort_mac_enable", mac_enable, 0);
        chk("abort_out_wr_en", out_wr_en, 0);
        tick();
        chk("abort_busy_2", busy, 0);
        chk("abort_clear_one_cycle", mac_clear, 0);
        repeat (40) tick();
        chk("abort_wr_count", wr_addr_q.size(), 1);
        chk("abort_n0_data", wr_data_q.size() > 0 ? wr_data_q[0] : 99999, exp_data[0]);
        chk("abort_no_done", done_cnt, 0);
        run_pass("post_abort", 1'b0, 1'b0);
        tick();

        // asynchronous reset while draining
        fill_rand(100);
        clear_mon();
        start = 1'b1;
        tick();
        start = 1'b0;
        i = 0;
        while (!mac_enable && i < 50) begin tick(); i++; end
        while (mac_enable && i < 50) begin tick(); i++; end
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_mac_clear", mac_clear, 0);
        chk("arst_mac_enable", mac_enable, 0);
        chk("arst_w_addr", w_addr, 0);
        chk("arst_in_addr", in_addr, 0);
        chk("arst_out_wr_en", out_wr_en, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_done", done, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("arst_no_write", wr_addr_q.size(), 0);
        run_pass("post_reset", 1'b1, 1'b0);

        // back-to-back: second start on the cycle after done
        tick();
        fill_rand(80);
        run_pass("b2b_a", 1'b0, 1'b0);
        for (int n = 0; n < NN; n++) first[n] = (n < wr_data_q.size()) ? wr_data_q[n] : 99999;
        tick();
        run_pass("b2b_b", 1'b0, 1'b0);
        for (int n = 0; n < NN; n++)
            chk($sformatf("b2b_same%0d", n), n < wr_data_q.size() ? wr_data_q[n] : 99999, first[n]);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dense_layer_ctrl.md
DENSE_LAYER_CTRL -- requirements
Module: dense_layer_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16, operand width of the sequenced MAC unit.
REQ-002 Parameter NUM_INPUTS, default 128, accumulations per neuron; equals the MAC's NUM_ACCUMS.
REQ-003 Parameter NUM_NEURONS, default 64, neurons per layer pass.
REQ-004 Parameter FRAC_BITS, default 8, right-shift applied to the accumulator before output.
REQ-005 Port clk, input, 1, single clock; all logic on the rising edge.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port start, input, 1, single-cycle request to run one layer pass.
REQ-008 Port abort, input, 1, synchronous cancel of a running pass.
REQ-009 Port relu_en, input, 1, applies ReLU to written outputs; sampled on start.
REQ-010 Port in_addr, output, clog2(NUM_INPUTS), input-buffer read address.
REQ-011 Port w_addr, output, clog2(NUM_INPUTS*NUM_NEURONS), weight-memory read address.
REQ-012 Port mac_enable, output, 1, MAC enable; operands are valid in the same cycle.
REQ-013 Port mac_clear, output, 1, MAC acc_clear.
REQ-014 Port mac_result, input, 2*DATA_WIDTH signed, MAC accumulator.
REQ-015 Port mac_valid, input, 1, MAC neuron-complete pulse.
REQ-016 Port out_wr_en / out_addr / out_data, output, 1 / clog2(NUM_NEURONS) / DATA_WIDTH signed, output-buffer write.
REQ-017 Port busy / done, output, 1 / 1, pass in progress / one-cycle completion pulse.

Function
REQ-018 The FSM SHALL have the states IDLE, CLEAR, RUN, DRAIN, WRITE and DONE; busy SHALL be 1 in every state except IDLE.
REQ-019 In IDLE, start=1 SHALL go to CLEAR, latch relu_en and zero the neuron index n; start outside IDLE SHALL be ignored.
REQ-020 CLEAR SHALL assert mac_clear for one cycle, zero the input index k, then go to RUN.
REQ-021 RUN SHALL last exactly NUM_INPUTS cycles with in_addr=k and w_addr=n*NUM_INPUTS+k, k incrementing 0..NUM_INPUTS-1; w_addr SHALL be generated by an incrementing counter, not a multiplier.
REQ-022 The memories have a 1-cycle synchronous read, so mac_enable SHALL be the RUN-issue flag delayed one register, giving exactly NUM_INPUTS enable cycles per neuron.
REQ-023 After k=NUM_INPUTS-1 the FSM SHALL enter DRAIN and hold until mac_valid=1 (expected 3 cycles after RUN exit), then go to WRITE.
REQ-024 WRITE SHALL last one cycle with out_wr_en=1, out_addr=n and out_data=f(mac_result), and SHALL assert mac_clear in the same cycle.
REQ-025 From WRITE, the FSM SHALL go to DONE if n=NUM_NEURONS-1; otherwise it SHALL increment n, zero k and re-enter RUN.
REQ-026 DONE SHALL pulse done=1 for one cycle and return to IDLE.
REQ-027 f(x) SHALL be an arithmetic right shift of x by FRAC_BITS, saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; when relu_en is latched, negative results SHALL become 0.
REQ-028 Per-neuron period SHALL be NUM_INPUTS+4 cycles, and start-to-done latency 1+NUM_NEURONS*(NUM_INPUTS+4) cycles.
REQ-029 abort=1 in any non-IDLE state SHALL drive one cycle of mac_clear, zero mac_enable and out_wr_en from the next cycle, return to IDLE with no done pulse, and suppress the write of the in-flight neuron.
REQ-030 abort together with start in IDLE SHALL have abort take priority: no pass starts.
REQ-031 mac_valid seen outside DRAIN SHALL be ignored.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE with n=0, k=0, and in_addr, w_addr, mac_enable, mac_clear, out_wr_en, out_addr, out_data, busy and done all 0.
REQ-033 Reset mid-pass SHALL discard the pass; the first start after reset SHALL begin a full pass from neuron 0.

Verification (NUM_INPUTS=4, NUM_NEURONS=3, FRAC_BITS=0, DATA_WIDTH=16, paired with a mac_unit instance)
REQ-034 All inputs=1, all weights=2, relu off, one start -> writes of 8 to addresses 0,1,2 in order; done exactly 25 cycles after start; w_addr sequence 0..11.
REQ-035 Products summing to 40000 -> out_data=32767; summing to -40000 with relu off -> -32768; with relu on -> 0.
REQ-036 Second start pulsed during RUN -> ignored; exactly 3 writes and one done.
REQ-037 abort in RUN of neuron 1 -> neuron 0 written, neuron 1 not written, no done, busy=0 two cycles later, mac_clear pulsed; a new start then yields a clean 3-neuron pass.
REQ-038 rst_n low during DRAIN -> all outputs 0 asynchronously; the next start gives the correct full pass.
REQ-039 Back-to-back passes (start on the cycle after done) -> second pass results are identical, with no accumulator carry-over.
